soft_error_event_logger: RTL and testbench
==========================================

SOFT_ERROR_EVENT_LOGGER -- requirements
Module: soft_error_event_logger

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, meaning event FIFO entries (power of two, 2..64).
REQ-002 SHALL have parameter TS_WIDTH, default 24, meaning timestamp counter width in bits.
REQ-003 SHALL have parameter CNT_WIDTH, default 16, meaning per-channel error counter width in bits.
REQ-004 SHALL have port i_clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-005 SHALL have port i_rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port error_A, input, 1, detector channel A error level, synchronous to i_clk.
REQ-007 SHALL have port error_B, input, 1, detector channel B error level, synchronous to i_clk.
REQ-008 SHALL have port i_clear, input, 1, single-cycle request to clear counters, sticky flag and FIFO.
REQ-009 SHALL have port o_evt_valid, output, 1, FIFO head holds an event.
REQ-010 SHALL have port i_evt_ready, input, 1, consumer accepts the head event.
REQ-011 SHALL have port o_evt_data, output, 2+TS_WIDTH, {type[1:0], timestamp}; type bit1 = B, bit0 = A.
REQ-012 SHALL have ports o_cnt_A and o_cnt_B, output, CNT_WIDTH each, saturating rising-edge counts per channel.
REQ-013 SHALL have port o_overflow, output, 1, sticky: an event was dropped because the FIFO was full.

Function
REQ-014 SHALL register error_A/error_B once per cycle and detect a rising edge as current=1 and previous=0.
REQ-015 SHALL treat rising edges on A and B in the same cycle as one event with type 2'b11.
REQ-016 SHALL stamp each event with the free-running timestamp value of the detection cycle; the timestamp wraps from all-ones to zero.
REQ-017 SHALL write a detected event into the FIFO at the end of the detection cycle; o_evt_valid SHALL be asserted from the next cycle (one-cycle latency).
REQ-018 SHALL complete a transfer on any cycle with o_evt_valid and i_evt_ready both high; o_evt_data SHALL remain stable while valid is high and ready is low.
REQ-019 SHALL, when the FIFO is full and no pop occurs, drop the new event and set o_overflow; o_cnt_A/o_cnt_B SHALL still increment.
REQ-020 SHALL, when the FIFO is full and a pop and a push occur in the same cycle, accept the push and leave o_overflow unchanged.
REQ-021 SHALL, when the FIFO is empty and a push occurs, leave o_evt_valid low in that cycle (no bypass).
REQ-022 SHALL increment o_cnt_A and o_cnt_B independently and hold them at all-ones on saturation.
REQ-023 SHALL, on i_clear, zero both counters, o_overflow and the FIFO in the next cycle; an edge detected in the i_clear cycle SHALL be discarded.
REQ-024 SHALL keep error levels held high as a single event; a new event needs a low cycle first.

Reset
REQ-025 SHALL, on i_rst, drive o_evt_valid=0, o_evt_data=0, o_cnt_A=0, o_cnt_B=0, o_overflow=0, clear the timestamp, the FIFO pointers and the previous-sample registers.
REQ-026 SHALL clear previous-sample registers to 0, so an input high on the first cycle after reset counts as a rising edge.
REQ-027 SHALL, when reset is asserted mid-transfer, discard all queued events without completing the transfer.

Configuration
REQ-028 SHALL, with SOFT_ERR_LOG_TIMESTAMP_EN defined, implement the timestamp counter and store it in o_evt_data.
REQ-029 SHALL, without SOFT_ERR_LOG_TIMESTAMP_EN, omit the timestamp counter and drive the timestamp field of o_evt_data to zero; port widths SHALL be unchanged.

Structure
REQ-030 SHALL place event type encodings (TYPE_A=2'b01, TYPE_B=2'b10, TYPE_AB=2'b11) and default widths in shared package soft_err_pkg.
REQ-031 SHALL implement the queue as sub-module soft_err_event_fifo: synchronous, first-word-fall-through, with full and empty flags.

Verification
REQ-032 SHALL cover: 0->1 on error_A at timestamp 100 -> one event {01,100}, valid one cycle later, o_cnt_A=1.
REQ-033 SHALL cover: A and B rise in the same cycle -> one event type 11, o_cnt_A=1, o_cnt_B=1.
REQ-034 SHALL cover: 9 edges with ready low and FIFO_DEPTH=8 -> 8 events queued, o_overflow=1, o_cnt_A=9.
REQ-035 SHALL cover: FIFO full, pop and edge in the same cycle -> push accepted, count stays 8, o_overflow=0.
REQ-036 SHALL cover: CNT_WIDTH=4 with 20 edges -> o_cnt_A saturates at 15; i_clear then zeroes the counter, flag and FIFO.
REQ-037 SHALL cover: error_A held high for 50 cycles -> exactly one event; with the macro undefined, the timestamp field is 0.

Source files
------------

// File: rtl/soft_err_pkg.sv
// soft_err_pkg -- shared definitions for the soft-error event logger.
// Holds the event type encodings, default parameter values and the helper
// that turns the per-channel rising-edge flags into an event type.
package soft_err_pkg;

    localparam int DEF_FIFO_DEPTH = 8;
    localparam int DEF_TS_WIDTH   = 24;
    localparam int DEF_CNT_WIDTH  = 16;

    // Event type: bit1 = channel B, bit0 = channel A.
    typedef enum logic [1:0] {
        TYPE_NONE = 2'b00,
        TYPE_A    = 2'b01,
        TYPE_B    = 2'b10,
        TYPE_AB   = 2'b11
    } evt_type_e;

    // Coincident edges on both channels collapse into one TYPE_AB event.
    function automatic evt_type_e encode_type(input logic rise_a, input logic rise_b);
        case ({rise_b, rise_a})
            2'b01:   return TYPE_A;
            2'b10:   return TYPE_B;
            2'b11:   return TYPE_AB;
            default: return TYPE_NONE;
        endcase
    endfunction

endpackage

// File: rtl/soft_err_event_fifo.sv
// soft_err_event_fifo -- synchronous first-word-fall-through event queue.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   flush        : synchronous empty of the queue (pointers and count)
//   push, wdata  : write request and entry; honoured when not full, or when
//                  full and a pop happens in the same cycle
//   pop          : remove the head entry (ignored while empty)
//   rdata        : head entry, valid whenever empty is low
//   full, empty  : occupancy flags derived from the registered count
module soft_err_event_fifo
    import soft_err_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH,
    parameter int WIDTH = 2 + DEF_TS_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Full-and-popping frees a slot this cycle, so the push may proceed.
    always_comb begin
        pop_ok_s  = pop & ~empty;
        push_ok_s = push & (~full | pop_ok_s);
    end

    assign full  = (count_r == (AW + 1)'(DEPTH));
    assign empty = (count_r == (AW + 1)'(0));
    assign rdata = mem_r[rd_ptr_r];

    // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth).
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW + 1){1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + (AW + 1)'(1);
                2'b01:   count_r <= count_r - (AW + 1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array; contents behind the pointers need no reset.
    always_ff @(posedge clk) begin
        if (push_ok_s && !flush) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

endmodule

// File: rtl/soft_error_event_logger.sv
// soft_error_event_logger -- detects rising edges on two soft-error detector
// channels, counts them per channel (saturating) and queues time-stamped events.
// Ports:
//   i_clk, i_rst          : clock, synchronous active-high reset
//   error_A, error_B      : detector error levels (synchronous to i_clk)
//   i_clear               : one-cycle clear of counters, overflow flag and queue
//   o_evt_valid/i_evt_ready/o_evt_data : event stream {type[1:0], timestamp}
//   o_cnt_A, o_cnt_B      : saturating rising-edge counts
//   o_overflow            : sticky, an event was dropped on a full queue
// Build option: define SOFT_ERR_LOG_TIMESTAMP_EN to include the free-running
// timestamp counter; otherwise the timestamp field reads as zero.
module soft_error_event_logger
    import soft_err_pkg::*;
#(
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int TS_WIDTH   = DEF_TS_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  error_A,
    input  logic                  error_B,
    input  logic                  i_clear,
    output logic                  o_evt_valid,
    input  logic                  i_evt_ready,
    output logic [TS_WIDTH+1:0]   o_evt_data,
    output logic [CNT_WIDTH-1:0]  o_cnt_A,
    output logic [CNT_WIDTH-1:0]  o_cnt_B,
    output logic                  o_overflow
);

    localparam int DW = 2 + TS_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    logic                 prev_a_r;
    logic                 prev_b_r;
    logic                 rise_a_s;
    logic                 rise_b_s;
    logic                 push_s;
    logic                 drop_s;
    evt_type_e            evt_type_s;
    logic [TS_WIDTH-1:0]  ts_s;
    logic [DW-1:0]        wdata_s;
    logic [DW-1:0]        rdata_s;
    logic                 full_s;
    logic                 empty_s;
    logic [CNT_WIDTH-1:0] cnt_a_r;
    logic [CNT_WIDTH-1:0] cnt_b_r;
    logic                 ovf_r;

`ifdef SOFT_ERR_LOG_TIMESTAMP_EN
    logic [TS_WIDTH-1:0] ts_r;

    // Free-running timestamp; wraps from all-ones to zero, not affected by i_clear.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ts_r <= {TS_WIDTH{1'b0}};
        end else begin
            ts_r <= ts_r + TS_WIDTH'(1);
        end
    end
    assign ts_s = ts_r;
`else
    assign ts_s = {TS_WIDTH{1'b0}};
`endif

    // Previous-sample registers; cleared to 0 so a level already high after reset is an edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            prev_a_r <= 1'b0;
            prev_b_r <= 1'b0;
        end else begin
            prev_a_r <= error_A;
            prev_b_r <= error_B;
        end
    end

    // Edge detection and event formation; edges seen during i_clear are discarded.
    always_comb begin
        rise_a_s   = error_A & ~prev_a_r & ~i_clear;
        rise_b_s   = error_B & ~prev_b_r & ~i_clear;
        evt_type_s = encode_type(rise_a_s, rise_b_s);
        push_s     = rise_a_s | rise_b_s;
        wdata_s    = {evt_type_s, ts_s};
        // A full queue only loses the event if the head is not leaving this cycle.
        drop_s     = push_s & full_s & ~i_evt_ready;
    end

    soft_err_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DW)
    ) u_fifo (
        .clk   (i_clk),
        .rst   (i_rst),
        .flush (i_clear),
        .push  (push_s),
        .wdata (wdata_s),
        .pop   (i_evt_ready),
        .rdata (rdata_s),
        .full  (full_s),
        .empty (empty_s)
    );

    // Saturating per-channel counters and sticky overflow flag.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            cnt_a_r <= {CNT_WIDTH{1'b0}};
            cnt_b_r <= {CNT_WIDTH{1'b0}};
            ovf_r   <= 1'b0;
        end else begin
            if (rise_a_s && (cnt_a_r != CNT_MAX)) begin
                cnt_a_r <= cnt_a_r + CNT_WIDTH'(1);
            end
            if (rise_b_s && (cnt_b_r != CNT_MAX)) begin
                cnt_b_r <= cnt_b_r + CNT_WIDTH'(1);
            end
            if (drop_s) begin
                ovf_r <= 1'b1;
            end
        end
    end

    // Head data is masked while empty so stale storage never appears on the port.
    always_comb begin
        o_evt_valid = ~empty_s;
        if (empty_s) begin
            o_evt_data = {DW{1'b0}};
        end else begin
            o_evt_data = rdata_s;
        end
    end

    assign o_cnt_A    = cnt_a_r;
    assign o_cnt_B    = cnt_b_r;
    assign o_overflow = ovf_r;

endmodule

// File: tb/tb_soft_error_event_logger.sv
// Directed self-checking bench for soft_error_event_logger. A second instance
// with 4-bit counters shares the stimulus to exercise counter saturation.
module tb_soft_error_event_logger;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        error_A;
    logic        error_B;
    logic        i_clear;
    logic        i_evt_ready;
    logic        o_evt_valid;
    logic [25:0] o_evt_data;
    logic [15:0] o_cnt_A;
    logic [15:0] o_cnt_B;
    logic        o_overflow;

    logic        s_evt_valid;
    logic [25:0] s_evt_data;
    logic [3:0]  s_cnt_A;
    logic [3:0]  s_cnt_B;
    logic        s_overflow;

    int checks = 0;
    int errors = 0;

    logic [23:0] tb_ts;
    logic [23:0] ts1;
    int          n;
    logic [25:0] first_d;
    logic [25:0] last_d;

    always #5 i_clk = ~i_clk;

    // Reference timestamp: cleared by reset, +1 every clock.
    always @(posedge i_clk) begin
        if (i_rst) tb_ts <= 24'd0;
        else       tb_ts <= tb_ts + 24'd1;
    end

    soft_error_event_logger dut (
        .i_clk (i_clk), .i_rst (i_rst), .error_A (error_A), .error_B (error_B),
        .i_clear (i_clear), .o_evt_valid (o_evt_valid), .i_evt_ready (i_evt_ready),
        .o_evt_data (o_evt_data), .o_cnt_A (o_cnt_A), .o_cnt_B (o_cnt_B),
        .o_overflow (o_overflow)
    );

    soft_error_event_logger #(.CNT_WIDTH(4)) dut_sat (
        .i_clk (i_clk), .i_rst (i_rst), .error_A (error_A), .error_B (error_B),
        .i_clear (i_clear), .o_evt_valid (s_evt_valid), .i_evt_ready (i_evt_ready),
        .o_evt_data (s_evt_data), .o_cnt_A (s_cnt_A), .o_cnt_B (s_cnt_B),
        .o_overflow (s_overflow)
    );

    function automatic logic [23:0] exp_ts(input logic [23:0] t);
`ifdef SOFT_ERR_LOG_TIMESTAMP_EN
        return t;
`else
        return 24'd0;
`endif
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic edge_a();
        error_A = 1'b1; step();
        error_A = 1'b0; step();
    endtask

    task automatic do_clear();
        i_clear = 1'b1; step();
        i_clear = 1'b0;
    endtask

    // Pops until empty (bounded), recording count, first and last data.
    task automatic drain(output int cnt, output logic [25:0] first, output logic [25:0] last);
        cnt = 0;
        first = 26'd0;
        last = 26'd0;
        i_evt_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (o_evt_valid) begin
                if (cnt == 0) first = o_evt_data;
                last = o_evt_data;
                cnt++;
                step();
            end
        end
        i_evt_ready = 1'b0;
    endtask

    initial begin
        i_rst = 1'b1; error_A = 1'b0; error_B = 1'b0; i_clear = 1'b0; i_evt_ready = 1'b0;
        step(); step();
        check("rst_valid", o_evt_valid, 1'b0);
        check("rst_data",  o_evt_data, 26'd0);
        check("rst_cnt_a", o_cnt_A, 16'd0);
        check("rst_cnt_b", o_cnt_B, 16'd0);
        check("rst_ovf",   o_overflow, 1'b0);
        i_rst = 1'b0;

        // Single A edge detected at timestamp 100.
        for (int i = 0; i < 300 && tb_ts != 24'd100; i++) step();
        ts1 = tb_ts;
        error_A = 1'b1;
        check("no_bypass_valid", o_evt_valid, 1'b0);
        step();
        error_A = 1'b0;
        check("a_valid", o_evt_valid, 1'b1);
        check("a_data",  o_evt_data, {2'b01, exp_ts(24'd100)});
        check("a_cnt",   o_cnt_A, 16'd1);
        i_evt_ready = 1'b1; step(); i_evt_ready = 1'b0;
        check("a_popped", o_evt_valid, 1'b0);

        // Coincident A and B edges.
        do_clear();
        check("clr_cnt_a", o_cnt_A, 16'd0);
        error_A = 1'b1; error_B = 1'b1; ts1 = tb_ts;
        step();
        error_A = 1'b0; error_B = 1'b0;
        check("ab_valid", o_evt_valid, 1'b1);
        check("ab_data",  o_evt_data, {2'b11, exp_ts(ts1)});
        check("ab_cnt_a", o_cnt_A, 16'd1);
        check("ab_cnt_b", o_cnt_B, 16'd1);
        i_evt_ready = 1'b1; step(); i_evt_ready = 1'b0;
        check("ab_single", o_evt_valid, 1'b0);

        // Nine edges with ready low: eight queued, one dropped.
        do_clear();
        ts1 = tb_ts;
        for (int i = 0; i < 9; i++) edge_a();
        check("ovf_set",   o_overflow, 1'b1);
        check("ovf_cnt_a", o_cnt_A, 16'd9);
        check("ovf_cnt_b", o_cnt_B, 16'd0);
        step(); step();
        check("ovf_head_stable", o_evt_data, {2'b01, exp_ts(ts1)});
        drain(n, first_d, last_d);
        check("ovf_queued", n, 8);
        check("ovf_first", first_d, {2'b01, exp_ts(ts1)});
        check("ovf_empty", o_evt_valid, 1'b0);

        // Full queue with simultaneous pop and push: push accepted, no overflow.
        do_clear();
        check("clr_ovf", o_overflow, 1'b0);
        for (int i = 0; i < 8; i++) edge_a();
        check("full_no_ovf", o_overflow, 1'b0);
        error_A = 1'b1; i_evt_ready = 1'b1; ts1 = tb_ts;
        step();
        error_A = 1'b0; i_evt_ready = 1'b0;
        check("pp_ovf", o_overflow, 1'b0);
        check("pp_cnt_a", o_cnt_A, 16'd9);
        drain(n, first_d, last_d);
        check("pp_queued", n, 8);
        check("pp_last", last_d, {2'b01, exp_ts(ts1)});

        // Saturation on the 4-bit counter instance, then clear.
        do_clear();
        for (int i = 0; i < 20; i++) edge_a();
        check("sat_cnt4", s_cnt_A, 4'd15);
        check("sat_cnt16", o_cnt_A, 16'd20);
        check("sat_ovf", s_overflow, 1'b1);
        do_clear();
        check("satclr_cnt", s_cnt_A, 4'd0);
        check("satclr_ovf", s_overflow, 1'b0);
        check("satclr_valid", s_evt_valid, 1'b0);

        // Edge arriving in the clear cycle is discarded.
        error_A = 1'b1; i_clear = 1'b1;
        step();
        i_clear = 1'b0; error_A = 1'b0;
        check("clr_edge_cnt", o_cnt_A, 16'd0);
        check("clr_edge_valid", o_evt_valid, 1'b0);
        step();

        // Level held high for 50 cycles yields one event.
        error_A = 1'b1; ts1 = tb_ts;
        for (int i = 0; i < 50; i++) step();
        check("hold_cnt", o_cnt_A, 16'd1);
        drain(n, first_d, last_d);
        check("hold_events", n, 1);
        check("hold_data", first_d, {2'b01, exp_ts(ts1)});
        error_A = 1'b0; step();

        // Reset mid-transfer discards the queue; a high input after reset is an edge.
        edge_a(); edge_a();
        check("pre_rst_valid", o_evt_valid, 1'b1);
        i_evt_ready = 1'b1; i_rst = 1'b1; error_A = 1'b1;
        step();
        i_rst = 1'b0; i_evt_ready = 1'b0;
        check("midrst_valid", o_evt_valid, 1'b0);
        check("midrst_data", o_evt_data, 26'd0);
        check("midrst_cnt", o_cnt_A, 16'd0);
        step();
        error_A = 1'b0;
        check("post_rst_edge_cnt", o_cnt_A, 16'd1);
        check("post_rst_edge_valid", o_evt_valid, 1'b1);
        check("post_rst_edge_data", o_evt_data, {2'b01, exp_ts(24'd0)});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
